// File: rtl/rx_seq_pkg.sv
// Shared types and helpers for the SiTCP-XG receive sequence checker.
// Lane 7 carries the first byte in stream order, so offsets count enabled lanes above a lane.
package rx_seq_pkg;

   localparam int LANES = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HUNT   = 2'd1,
      ST_LOCKED = 2'd2
   } state_e;

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] c;
      c = '0;
      for (int i = 0; i < LANES; i++) begin
         c = c + {3'd0, v[i]};
      end
      return c;
   endfunction

   function automatic logic [2:0] lane_offset(input logic [7:0] wenb, input int lane);
      logic [3:0] c;
      c = '0;
      for (int j = 0; j < LANES; j++) begin
         if (j > lane) begin
            c = c + {3'd0, wenb[j]};
         end
      end
      return c[2:0];
   endfunction

endpackage

// File: rtl/rx_seq_lane_cmp.sv
// Registered per-lane compare stage: mismatch mask, byte count of the word and
// the lowest-offset mismatch (offset, expected, received).
module rx_seq_lane_cmp
   import rx_seq_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        vld_i,
   input  logic        chk_enb_i,
   input  logic [7:0]  e_i,
   input  logic [7:0]  wenb_i,
   input  logic [63:0] wdat_i,
   output logic [7:0]  mm_mask_o,
   output logic [3:0]  n_o,
   output logic [2:0]  first_off_o,
   output logic [7:0]  first_exp_o,
   output logic [7:0]  first_got_o
);

   logic [7:0] mm_mask_d, mm_mask_q;
   logic [3:0] n_d, n_q;
   logic [2:0] first_off_d, first_off_q;
   logic [7:0] first_exp_d, first_exp_q;
   logic [7:0] first_got_d, first_got_q;
   logic [2:0] off_lane;
   logic [7:0] exp_lane;
   logic [7:0] got_lane;

   // Ascending scan: the last hit is the highest lane, i.e. the lowest stream offset.
   always_comb begin
      mm_mask_d   = '0;
      first_off_d = '0;
      first_exp_d = '0;
      first_got_d = '0;
      off_lane    = '0;
      exp_lane    = '0;
      got_lane    = '0;
      n_d         = vld_i ? popcount8(wenb_i) : 4'd0;
      for (int i = 0; i < LANES; i++) begin
         off_lane = lane_offset(wenb_i, i);
         exp_lane = e_i + {5'd0, off_lane};
         got_lane = wdat_i[i*8 +: 8];
         if (vld_i && chk_enb_i && wenb_i[i] && (got_lane != exp_lane)) begin
            mm_mask_d[i] = 1'b1;
            first_off_d  = off_lane;
            first_exp_d  = exp_lane;
            first_got_d  = got_lane;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         mm_mask_q   <= '0;
         n_q         <= '0;
         first_off_q <= '0;
         first_exp_q <= '0;
         first_got_q <= '0;
      end else begin
         mm_mask_q   <= mm_mask_d;
         n_q         <= n_d;
         first_off_q <= first_off_d;
         first_exp_q <= first_exp_d;
         first_got_q <= first_got_d;
      end
   end

   assign mm_mask_o   = mm_mask_q;
   assign n_o         = n_q;
   assign first_off_o = first_off_q;
   assign first_exp_o = first_exp_q;
   assign first_got_o = first_got_q;

endmodule

// File: rtl/rx_seq_checker.sv
// Passive checker on the SiTCP-XG RX buffer write port: verifies a mod-256
// incrementing byte stream and keeps byte/error counters and first-error capture.
module rx_seq_checker
   import rx_seq_pkg::*;
#(
   parameter int CNT_W = 64,
   parameter int ERR_W = 32
) (
   input  logic             CLK156M,
   input  logic             RSTn,
   input  logic             SiTCPXG_ESTABLISHED,
   input  logic [7:0]       SiTCPXG_RX_WENB,
   input  logic [63:0]      SiTCPXG_RX_WDAT,
   input  logic             CHK_ENB,
   input  logic             CLR_CNT,
   output logic [CNT_W-1:0] BYTE_COUNT,
   output logic [ERR_W-1:0] ERR_COUNT,
   output logic             ERR_FLAG,
   output logic [CNT_W-1:0] FIRST_ERR_POS,
   output logic [7:0]       FIRST_ERR_EXP,
   output logic [7:0]       FIRST_ERR_GOT,
   output logic             LOCKED
);

   localparam int ERR_W1 = ERR_W + 1;

   logic [1:0]  rst_sync_q;
   logic        rst_n_int;

   logic        est_p0_q, chk_p0_q, clr_p0_q;
   logic [7:0]  wenb_p0_q;
   logic [63:0] wdat_p0_q;

   state_e      state_q, state_d;
   logic [7:0]  e_q, e_d;
   logic [7:0]  e_use, seed;
   logic        start, hunt_eff, wr_vld;
   logic        clr_p1_q;
   logic [7:0]  mm_mask_p1;
   logic [3:0]  n_p1;
   logic [2:0]  first_off_p1;
   logic [7:0]  first_exp_p1, first_got_p1;

   logic [CNT_W-1:0] bc_q, bc_d, bc_base;
   logic [ERR_W-1:0] err_q, err_d, err_base;
   logic [ERR_W:0]   err_sum;
   logic [3:0]       mm_cnt;
   logic             flag_q, flag_d, flag_base;
   logic [CNT_W-1:0] pos_q, pos_d;
   logic [7:0]       fexp_q, fexp_d, fgot_q, fgot_d;

   // Asynchronous assert, two-flop synchronised release.
   always_ff @(posedge CLK156M or negedge RSTn) begin
      if (!RSTn) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end
   assign rst_n_int = rst_sync_q[1];

   // ---- S0: input registers ----
   always_ff @(posedge CLK156M or negedge rst_n_int) begin
      if (!rst_n_int) begin
         est_p0_q  <= 1'b0;
         chk_p0_q  <= 1'b0;
         clr_p0_q  <= 1'b0;
         wenb_p0_q <= '0;
         wdat_p0_q <= '0;
      end else begin
         est_p0_q  <= SiTCPXG_ESTABLISHED;
         chk_p0_q  <= CHK_ENB;
         clr_p0_q  <= CLR_CNT;
         wenb_p0_q <= SiTCPXG_RX_WENB;
         wdat_p0_q <= SiTCPXG_RX_WDAT;
      end
   end

   // ---- S1: FSM, expected-byte tracking, lane compare ----
   // A word arriving with the establishing edge is treated as a hunting word.
   always_comb begin
      start    = est_p0_q && (state_q == ST_IDLE);
      hunt_eff = start || (state_q == ST_HUNT);
      wr_vld   = est_p0_q && (wenb_p0_q != 8'd0);
      seed     = 8'd0;
      for (int i = 0; i < LANES; i++) begin
         if (wenb_p0_q[i]) begin
            seed = wdat_p0_q[i*8 +: 8];
         end
      end
      e_use   = hunt_eff ? seed : e_q;
      state_d = state_q;
      e_d     = e_q;
      if (!est_p0_q) begin
         state_d = ST_IDLE;
         e_d     = 8'd0;
      end else if (wr_vld) begin
         state_d = ST_LOCKED;
         e_d     = e_use + {4'd0, popcount8(wenb_p0_q)};
      end else if (hunt_eff) begin
         state_d = ST_HUNT;
      end
   end

   always_ff @(posedge CLK156M or negedge rst_n_int) begin
      if (!rst_n_int) begin
         state_q  <= ST_IDLE;
         e_q      <= '0;
         clr_p1_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         e_q      <= e_d;
         clr_p1_q <= clr_p0_q | start;
      end
   end

   rx_seq_lane_cmp u_lane_cmp (
      .clk_i       (CLK156M),
      .rst_n_i     (rst_n_int),
      .vld_i       (wr_vld),
      .chk_enb_i   (chk_p0_q),
      .e_i         (e_use),
      .wenb_i      (wenb_p0_q),
      .wdat_i      (wdat_p0_q),
      .mm_mask_o   (mm_mask_p1),
      .n_o         (n_p1),
      .first_off_o (first_off_p1),
      .first_exp_o (first_exp_p1),
      .first_got_o (first_got_p1)
   );

   // ---- S2: counters, sticky flag, first-error capture ----
   // A clear in the same cycle as a word is applied before that word is added.
   always_comb begin
      bc_base   = clr_p1_q ? '0 : bc_q;
      err_base  = clr_p1_q ? '0 : err_q;
      flag_base = clr_p1_q ? 1'b0 : flag_q;
      pos_d     = clr_p1_q ? '0 : pos_q;
      fexp_d    = clr_p1_q ? 8'd0 : fexp_q;
      fgot_d    = clr_p1_q ? 8'd0 : fgot_q;
      mm_cnt    = popcount8(mm_mask_p1);
      bc_d      = bc_base + CNT_W'(n_p1);
      err_sum   = {1'b0, err_base} + ERR_W1'(mm_cnt);
      err_d     = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
      flag_d    = flag_base;
      if (!flag_base && (mm_mask_p1 != 8'd0)) begin
         flag_d = 1'b1;
         pos_d  = bc_base + CNT_W'(first_off_p1);
         fexp_d = first_exp_p1;
         fgot_d = first_got_p1;
      end
   end

   always_ff @(posedge CLK156M or negedge rst_n_int) begin
      if (!rst_n_int) begin
         bc_q   <= '0;
         err_q  <= '0;
         flag_q <= 1'b0;
         pos_q  <= '0;
         fexp_q <= '0;
         fgot_q <= '0;
      end else begin
         bc_q   <= bc_d;
         err_q  <= err_d;
         flag_q <= flag_d;
         pos_q  <= pos_d;
         fexp_q <= fexp_d;
         fgot_q <= fgot_d;
      end
   end

   assign BYTE_COUNT    = bc_q;
   assign ERR_COUNT     = err_q;
   assign ERR_FLAG      = flag_q;
   assign FIRST_ERR_POS = pos_q;
   assign FIRST_ERR_EXP = fexp_q;
   assign FIRST_ERR_GOT = fgot_q;
   assign LOCKED        = (state_q == ST_LOCKED);

endmodule
